// File: rtl/pio_out_blink.sv
// Avalon-MM output port: WIDTH channels with atomic set/clear/toggle, pin readback
// and per-channel blinking driven by a shared half-period prescaler.
module pio_out_blink #(
    parameter int unsigned WIDTH   = 10,
    parameter int unsigned PRESC_W = 24,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic [WIDTH-1:0]  out_port
);

    localparam logic [2:0] AddrData   = 3'd0;
    localparam logic [2:0] AddrBlink  = 3'd1;
    localparam logic [2:0] AddrPeriod = 3'd2;
    localparam logic [2:0] AddrSet    = 3'd3;
    localparam logic [2:0] AddrClr    = 3'd4;
    localparam logic [2:0] AddrToggle = 3'd5;
    localparam logic [2:0] AddrPins   = 3'd6;

    logic               wr;
    logic [WIDTH-1:0]   wdata_ch;
    logic [PRESC_W-1:0] wdata_per;

    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   blink_en_q, blink_en_d;
    logic [PRESC_W-1:0] period_q, period_d;
    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic               phase_q, phase_d;

    logic               unused_wdata;

    assign wr        = chipselect & ~write_n;
    assign wdata_ch  = writedata[WIDTH-1:0];
    assign wdata_per = writedata[PRESC_W-1:0];

    // Bus bits above both field widths are architecturally ignored.
    assign unused_wdata = ^writedata;

    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        period_d   = period_q;
        if (wr) begin
            case (address)
                AddrData:   data_d     = wdata_ch;
                AddrBlink:  blink_en_d = wdata_ch;
                AddrPeriod: period_d   = wdata_per;
                AddrSet:    data_d     = data_q | wdata_ch;
                AddrClr:    data_d     = data_q & ~wdata_ch;
                AddrToggle: data_d     = data_q ^ wdata_ch;
                default:    ;
            endcase
        end
    end

    // Each phase lasts period+1 cycles; a PERIOD write restarts in the "on" phase.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (wr && (address == AddrPeriod)) begin
            cnt_d   = wdata_per;
            phase_d = 1'b1;
        end else if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == '0) begin
            cnt_d   = period_q;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q - PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            blink_en_q <= '0;
            period_q   <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b1;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
        end
    end

    assign out_port = data_q & ~(blink_en_q & {WIDTH{~phase_q}});

    always_comb begin
        readdata = '0;
        case (address)
            AddrData:   readdata = DATA_W'(data_q);
            AddrBlink:  readdata = DATA_W'(blink_en_q);
            AddrPeriod: readdata = DATA_W'(period_q);
            AddrPins:   readdata = DATA_W'(out_port);
            default:    readdata = '0;
        endcase
    end

endmodule

// File: doc/pio_out_blink.md
Name: pio_out_blink

Overview:
- Parametrised Avalon-MM slave output port for the NIOS system; successor to the fixed 10-bit LED output register.
- Drives WIDTH output channels (LEDs, enables, strobes).
- Adds atomic bit set, clear and toggle writes, a readback of the live pin state, and per-channel hardware blinking from a shared programmable prescaler, so software does not have to bit-bang.

Parameters:
- WIDTH, 10: number of output channels; 1..32.
- PRESC_W, 24: prescaler counter/register width; 1..32.
- DATA_W, 32: Avalon data bus width; must be >= WIDTH and >= PRESC_W.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  3  word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  DATA_W  write data.
- readdata  output  DATA_W  read data; combinational, zero wait states.
- out_port  output  WIDTH  channel outputs.

Behaviour:
- Write strobe: wr = chipselect & ~write_n.
- Writes take effect at the clk edge where wr is high. Registers and out_port reflect the write from the following cycle.
- Register map (bits above the field width read 0; writes to those bits are ignored):
  - 0 DATA (rw): data[WIDTH-1:0] <= writedata[WIDTH-1:0].
  - 1 BLINK_EN (rw): per-channel blink enable.
  - 2 PERIOD (rw): half-period reload value, PRESC_W bits.
  - 3 SET (wo, reads 0): data <= data | writedata.
  - 4 CLR (wo, reads 0): data <= data & ~writedata.
  - 5 TOGGLE (wo, reads 0): data <= data ^ writedata.
  - 6 PINS (ro): current out_port. Writes ignored.
  - 7: reserved. Reads 0; writes ignored.
- readdata: combinational mux on address. Not qualified by chipselect. Reads have no side effects.
- Prescaler: registers cnt (PRESC_W bits) and phase (1 bit). Evaluated every clk edge in this priority order:
  - Write to PERIOD: cnt <= new value, phase <= 1.
  - Else if period == 0: cnt <= 0, phase <= 1 (blinking frozen at the "on" phase).
  - Else if cnt == 0: cnt <= period, phase <= ~phase.
  - Else: cnt <= cnt - 1.
  - Result: each phase lasts period+1 cycles, so a full blink cycle is 2*(period+1) cycles.
- Output: out_port = data & ~(blink_en & {WIDTH{~phase}}).
  - Combinational from registers; no extra latency.
  - A channel with its data bit 0 is always 0, regardless of blink.
- Only one address is accessed per cycle, so SET, CLR and TOGGLE cannot collide with each other.
- A blink phase change in the same cycle as a DATA write is well defined: both registers update at that edge.
- Reset (asserted asynchronously at any time, including mid-count):
  - data, blink_en, period, cnt <= 0; phase <= 1.
  - out_port = 0 and readdata for address 0/1/2/6 = 0 immediately, without waiting for a clock.
- Release of reset is synchronous to clk; the first write is accepted on the first edge after release.

Test Plan:
- Reset, then write DATA=0x2A5 -> out_port=0x2A5 the next cycle; reading address 0 and address 6 both return 0x2A5; reading address 3 returns 0.
- Starting from DATA=0x0F0: SET 0x003 -> 0x0F3; CLR 0x030 -> 0x0C3; TOGGLE 0x3FF -> 0x33C. Each result is visible one cycle after its write edge.
- DATA=0x001, BLINK_EN=0x001, PERIOD=3 -> out_port[0] is 1 for 4 cycles after the PERIOD write edge, then 0 for 4, then 1 for 4 (period 8 cycles). Other bits stay 0.
- Blink running, write PERIOD=0 -> phase forced to 1 and out_port[0] held at 1. Then write BLINK_EN=0 and PERIOD=1 -> out_port stays 0x001 (no blink).
- Assert reset_n low mid-blink while between clock edges -> out_port=0 and readdata(addr 6)=0 at once. After release, PINS reads 0 and a new PERIOD write restarts blinking with phase=1.
- Write to address 7 and to address 6 with 0x3FF -> no register changes; address 7 reads 0. WIDTH=4 instance: write DATA=0xFFFFFFFF -> readdata=0x0000000F.
